serial_crc_engine: RTL
======================

Name: serial_crc_engine

Overview:
Byte-stream CRC engine built around the XOR primitive. It consumes bytes over a valid/ready handshake, runs them MSB-first through a bit-serial LFSR (one bit per clock), and presents the final CRC over a second valid/ready handshake when the byte tagged "last" has been shifted. It is the consumer stage that uses the XOR gate as the LFSR feedback element, and it is the first sequential block in the combinational-to-sequential progression.

Parameters:
CRC_W, 8, CRC register width; the bench covers only 8.
POLY, 8'h07, generator polynomial with the implicit x^CRC_W term omitted.
INIT, 8'h00, CRC register value at reset, after clear, and after each result is consumed.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous abort; highest priority after rst.
in_valid  input  1  in_data/in_last are valid.
in_ready  output  1  engine can accept a byte this cycle.
in_data  input  8  data byte, processed MSB first.
in_last  input  1  byte is the final byte of the message.
out_valid  output  1  out_crc holds a final CRC.
out_ready  input  1  downstream accepts out_crc.
out_crc  output  CRC_W  final CRC, no reflection, no final XOR.

Behaviour:
- Reset (async, rst=1): state=IDLE, crc=INIT, bit_cnt=0, shift reg=0, last_q=0, out_valid=0, out_crc=0.
- in_ready is combinational: 1 iff state==IDLE and rst=0.
- out_valid is registered: 1 iff state==OUT.
- There are three states: IDLE, SHIFT and OUT.
- IDLE:
  - On in_valid && in_ready, latch in_data into the shift register and in_last into last_q, set bit_cnt=0, and go to SHIFT.
  - Without in_valid, hold all state.
- SHIFT (lasts exactly 8 cycles):
  - Each cycle: fb = crc[CRC_W-1] XOR sr[7]; crc <= {crc[CRC_W-2:0],0} XOR (fb ? POLY : 0); sr <= sr<<1; bit_cnt++.
  - On the cycle with bit_cnt==7, apply the update, then go to OUT if last_q=1, else go to IDLE.
  - in_valid is ignored (in_ready=0).
- OUT:
  - out_crc holds the final CRC and stays stable while out_valid=1 && out_ready=0.
  - On out_ready=1, go to IDLE and set crc=INIT.
  - out_crc keeps its last value after the handshake.
- Timing:
  - Throughput is 9 cycles per byte (1 accept cycle plus 8 shift cycles).
  - If the last byte is accepted at edge T, out_valid rises after edge T+8 and is seen high in cycle T+8..T+9.
  - Minimum latency is 9 edges from accept to the handshake being possible.
- Multi-byte messages: crc is not re-initialised between bytes of one message.
- in_last=1 on the first byte gives a single-byte message.
- clear=1 on any edge forces state=IDLE, crc=INIT, bit_cnt=0 and out_valid=0, and discards any in-flight byte and result.
  - A simultaneous in_valid is NOT accepted on that edge.
- clear and out_ready together in OUT: clear wins, with the same result (IDLE, crc=INIT).
- rst asserted mid-SHIFT or mid-OUT: immediate return to reset values; no partial result is emitted.
- Exactly one bit is consumed per SHIFT cycle. bit_cnt wraps 7→0 only via the state change and never counts past 7.

Test Plan:
- Single byte 8'h01 with last=1, out_ready=1 → out_crc=8'h07; out_valid high for exactly one cycle, 9 edges after accept.
- Single byte 8'h80 with last=1 → out_crc=8'h89. Then 8'h00 with last=1 → 8'h00, confirming crc returned to INIT between messages.
- ASCII "123456789" (8'h31..8'h39), last on 8'h39, in_valid held high continuously → in_ready pulses once every 9 cycles; out_crc=8'hF4.
- Backpressure: same message with out_ready=0 for 20 cycles → out_valid stays 1, out_crc stays 8'hF4, in_ready stays 0. Raising out_ready completes the handshake and in_ready=1 on the next cycle.
- clear asserted in the 4th SHIFT cycle of byte 8'h80, then 8'h01 with last=1 is sent → out_crc=8'h07, with no stale contribution from the aborted byte.
- rst pulsed asynchronously (between edges) while in OUT → out_valid drops immediately, out_crc=0, in_ready=1 after rst falls. The next message 8'h01 gives 8'h07.

Source files
------------

// File: rtl/serial_crc_engine.sv
// Bit-serial CRC engine: bytes in over valid/ready, MSB first through an LFSR,
// final CRC out over valid/ready once the byte tagged last has been shifted.
module serial_crc_engine #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 'h07,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CRC_W-1:0] out_crc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] crc_nx;
  logic [CRC_W-1:0] crc_step;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_nx;
  logic [7:0]       sr;
  logic [7:0]       sr_nx;
  logic             last_q;
  logic             last_nx;
  logic [CRC_W-1:0] out_crc_nx;
  logic             fb;
  logic             accept;

  // One LFSR step: XOR of register MSB and next message bit drives feedback
  assign fb       = crc[CRC_W-1] ^ sr[7];
  assign crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  assign in_ready = (state == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready && !clear;

  always_comb begin
    state_nx   = state;
    crc_nx     = crc;
    bit_cnt_nx = bit_cnt;
    sr_nx      = sr;
    last_nx    = last_q;
    out_crc_nx = out_crc;
    if (clear) begin
      state_nx   = S_IDLE;
      crc_nx     = INIT;
      bit_cnt_nx = 3'd0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (accept) begin
            sr_nx      = in_data;
            last_nx    = in_last;
            bit_cnt_nx = 3'd0;
            state_nx   = S_SHIFT;
          end
        end
        (state == S_SHIFT): begin
          crc_nx = crc_step;
          sr_nx  = {sr[6:0], 1'b0};
          if (bit_cnt == 3'd7) begin
            bit_cnt_nx = 3'd0;
            if (last_q) begin
              state_nx   = S_OUT;
              out_crc_nx = crc_step;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
        (state == S_OUT): begin
          if (out_ready) begin
            state_nx = S_IDLE;
            crc_nx   = INIT;
          end
        end
        default: begin
          state_nx   = S_IDLE;
          crc_nx     = INIT;
          bit_cnt_nx = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      crc       <= INIT;
      bit_cnt   <= 3'd0;
      sr        <= 8'd0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_crc   <= '0;
    end else begin
      state     <= state_nx;
      crc       <= crc_nx;
      bit_cnt   <= bit_cnt_nx;
      sr        <= sr_nx;
      last_q    <= last_nx;
      out_valid <= (state_nx == S_OUT);
      out_crc   <= out_crc_nx;
    end
  end

endmodule
